// File: rtl/temp_conv_pkg.sv
// ============================================================================
// Module  : temp_conv_pkg
// Brief   : Shared types and constants for the temperature-conversion arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package temp_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic FMT_F2C  = 1'b1;
  localparam logic FMT_C2F  = 1'b0;
  localparam int   F_OFFSET = 32;
  localparam int   NREQ     = 2;

endpackage

`default_nettype wire

// File: rtl/temp_conv_arbiter_rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-input round-robin arbiter; pointer flips away from the winner
//           whenever a grant is consumed (advance).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import temp_conv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt
);

  // r_ptr = 0 favours requester 0, r_ptr = 1 favours requester 1
  logic r_ptr;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (advance) begin
      r_ptr <= gnt[0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/temp_conv_arbiter.sv
// ============================================================================
// Module  : temp_conv_arbiter
// Brief   : Shares one registered-read temperature ROM between two requesters
//           with round-robin arbitration and per-requester response channels.
//           Optional macro TEMP_CONV_RANGE_FLAG_EN adds rsp0_err/rsp1_err.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module temp_conv_arbiter
  import temp_conv_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [AWIDTH-1:0] req0_temp,
  input  logic [AWIDTH-1:0] req1_temp,
  input  logic              req0_fmt,
  input  logic              req1_fmt,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [DWIDTH-1:0] rsp0_data,
  output logic [DWIDTH-1:0] rsp1_data,
`ifdef TEMP_CONV_RANGE_FLAG_EN
  output logic              rsp0_err,
  output logic              rsp1_err,
`endif
  output logic [AWIDTH-1:0] rom_addr,
  output logic              rom_format_sel,
  input  logic [DWIDTH-1:0] rom_data
);

  state_t            r_state;
  state_t            w_next_state;
  logic [NREQ-1:0]   w_gnt;
  logic              w_accept;
  logic              w_rsp_hs;
  logic [AWIDTH-1:0] r_temp;
  logic              r_fmt;
  logic              r_idx;
  logic [DWIDTH-1:0] r_result;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1_valid, req0_valid}),
    .advance (w_accept),
    .gnt     (w_gnt)
  );

  assign w_accept = req0_ready | req1_ready;
  assign w_rsp_hs = (r_idx ? rsp1_ready : rsp0_ready) & (r_state == RESP);

  // ROM inputs come straight from the request latches so they are already
  // settled in ISSUE and cannot move during WAIT.
  assign rom_addr       = r_temp;
  assign rom_format_sel = r_fmt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    w_next_state = RESP;
      RESP:    if (w_rsp_hs) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Ready is gated by reset so the outputs read as reset values while held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_data  = '0;
    rsp1_data  = '0;
    if (r_state == IDLE && !reset) begin
      req0_ready = w_gnt[0];
      req1_ready = w_gnt[1];
    end
    if (r_state == RESP) begin
      rsp0_valid = ~r_idx;
      rsp1_valid = r_idx;
    end
    if (r_idx) begin
      rsp1_data = r_result;
    end else begin
      rsp0_data = r_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_temp   <= '0;
      r_fmt    <= FMT_C2F;
      r_idx    <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_temp <= w_gnt[1] ? req1_temp : req0_temp;
        r_fmt  <= w_gnt[1] ? req1_fmt  : req0_fmt;
        r_idx  <= w_gnt[1];
      end
      if (r_state == WAIT) begin
        r_result <= rom_data;
      end
    end
  end

`ifdef TEMP_CONV_RANGE_FLAG_EN
  // Flags an F-to-C input below freezing that the ROM clamps to zero.
  logic r_err;
  logic w_err_in;

  assign w_err_in = w_gnt[1]
                  ? (req1_fmt == FMT_F2C) && (req1_temp < AWIDTH'(F_OFFSET))
                  : (req0_fmt == FMT_F2C) && (req0_temp < AWIDTH'(F_OFFSET));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_err_in;
    end
  end

  assign rsp0_err = ~r_idx & r_err;
  assign rsp1_err = r_idx & r_err;
`endif

endmodule

`default_nettype wire
